change_dispenser: RTL and testbench
===================================

# change_dispenser

Returns change to the customer after a sale. Accepts a change amount in cents from the vending controller and pays it out as a sequence of individual coin requests to the coin-ejection mechanism. Uses largest-coin-first selection and a valid/ack handshake per coin. Coin codes are the same 3-bit one-hot encoding the vending controller uses for coin-entry buttons: quarter = 3'd4, dime = 3'd2, nickel = 3'd1.

## Interface

- `GAP` (default 2): idle cycles inserted between coins so the ejector can settle; legal range 0..15.
- `clock` (in, 1): single system clock; all state changes on its rising edge.
- `reset` (in, 1): asynchronous, active-low reset.
- `start` (in, 1): one-cycle request to dispense `change`; sampled only in IDLE.
- `change` (in, 8): amount to return in cents, 0..255; sampled on the `start` edge.
- `ack` (in, 1): ejector has taken the presented coin; a transfer occurs when `coin_valid` and `ack` are both high at a rising edge.
- `coin` (out, 3): coin being requested (4/2/1); 3'd0 when `coin_valid` is low.
- `coin_valid` (out, 1): `coin` is a valid request.
- `busy` (out, 1): high in every state except IDLE.
- `done` (out, 1): one-cycle pulse when a payout completes.
- `error` (out, 1): sticky flag; last request was rejected.
- `remaining` (out, 8): cents still to be dispensed.
- `coins_issued` (out, 6): coins transferred in the current or last payout.

## Operation

- States: IDLE, ISSUE, GAP_WAIT, FINISH. All outputs are Moore-type, decoded from the state and registers.
- **IDLE**, on `start`:
  - `change % 5 != 0`: set `error`, remain in IDLE, leave `remaining` and `coins_issued` unchanged, no `done`.
  - `change == 0`: clear `error`, `remaining` = 0, `coins_issued` = 0, go to FINISH.
  - Otherwise: clear `error`, `remaining` = `change`, `coins_issued` = 0, go to ISSUE.
- **ISSUE**: `coin_valid` = 1. `coin` = quarter if `remaining` >= 25, else dime if >= 10, else nickel.
  - On transfer: `remaining` -= coin value (5, 10 or 25) and `coins_issued` += 1.
  - If the new `remaining` is 0, go to FINISH. Otherwise go to GAP_WAIT, or stay in ISSUE when `GAP` = 0.
  - Without `ack`, stay in ISSUE with `coin` and `remaining` held stable.
- **GAP_WAIT**: `coin_valid` = 0. A counter runs `GAP` cycles, then returns to ISSUE. `ack` is ignored here.
- **FINISH**: `done` = 1 for exactly one cycle, then IDLE.
- `start` is ignored in every state other than IDLE, including FINISH.
- Arithmetic is 8-bit unsigned. `remaining` never underflows because the selected coin value is always <= `remaining`, which is a non-zero multiple of 5.
- `coins_issued` is 6 bits. The worst case is 245 = 9 quarters + 2 dimes = 11 coins, so no wrap occurs.

## Timing

- Reset (`reset` low) asynchronously forces:
  - state IDLE;
  - `coin` = 0, `coin_valid` = 0, `busy` = 0, `done` = 0, `error` = 0;
  - `remaining` = 0, `coins_issued` = 0;
  - gap counter 0.
- Reset in the middle of a payout aborts it. No `done` is produced, and the next payout needs a new `start`.
- Latency:
  - `coin_valid` rises in the cycle after the `start` edge.
  - After a transfer edge, the next `coin_valid` rises `GAP` + 1 cycles later.
  - `done` is high in the cycle after the final transfer edge.
  - For `change` = 0, `done` is high in the cycle after the `start` edge.
- `error` is updated only on an accepted IDLE `start` and is held otherwise.

## Test plan

- **Basic payout**: `GAP` = 2, `ack` tied high, `start` with `change` = 40 at edge 0.
  - `coin_valid` high in cycles 1, 4 and 7 with `coin` = 4, 2, 1.
  - `remaining` reads 15, then 5, then 0.
  - `done` high in cycle 8; `busy` low from cycle 9; `coins_issued` = 3.
- **Backpressure**: `change` = 25, `ack` held low for 5 cycles and then high.
  - `coin` = 3'd4 and `coin_valid` = 1 held stable for 6 cycles; `remaining` stays 25 until the transfer.
  - `done` follows one cycle after the transfer.
- **Zero and invalid amounts**:
  - `change` = 0: `done` in cycle 1, `coin_valid` never rises, `coins_issued` = 0.
  - `change` = 37: `error` = 1, `busy` stays 0, no coin and no `done`.
  - Then `change` = 10: `error` clears and a single dime is dispensed.
- **Maximum payout**: `change` = 245 with `GAP` = 0 and `ack` high.
  - 9 quarters followed by 2 dimes, back to back, one per cycle.
  - Ends with `coins_issued` = 11 and `remaining` = 0; also check that 250 gives 10 quarters.
- **Start while busy**: pulse `start` with `change` = 5 during ISSUE, during GAP_WAIT, and in the FINISH cycle.
  - No effect on `remaining`, `coins_issued` or the coin sequence.
- **Reset mid-payout**: drive `reset` low between clock edges while in ISSUE with `remaining` = 20.
  - All outputs go to 0 immediately, before the next edge, and no `done` is produced.
  - After release, a `start` with `change` = 15 dispenses a dime and then a nickel.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser
// Pays out a change amount as a sequence of single-coin requests to the
// coin ejector. It always picks the largest coin first (quarter, dime,
// nickel) and uses a valid/ack handshake for each coin.
//
// Parameters
//   GAP          : idle cycles between coins so the ejector can settle (0..15)
// Ports
//   clock        : system clock, rising edge
//   reset        : asynchronous, active-low reset
//   start        : one-cycle payout request, honoured only when idle
//   change       : amount to return in cents, captured with start
//   ack          : ejector took the presented coin (transfer = coin_valid & ack)
//   coin         : one-hot coin code (4 = quarter, 2 = dime, 1 = nickel), 0 when not valid
//   coin_valid   : coin holds a valid request
//   busy         : high whenever a payout is in progress
//   done         : one-cycle pulse when a payout completes
//   error        : sticky, the last start carried an amount that is not a multiple of 5
//   remaining    : cents still to be paid out
//   coins_issued : coins transferred in the current or last payout
module change_dispenser #(
  parameter int unsigned GAP = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] change,
  input  logic       ack,
  output logic [2:0] coin,
  output logic       coin_valid,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] remaining,
  output logic [5:0] coins_issued
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP_WAIT,
    S_FINISH
  } state_t;

  // The gap counter is loaded with GAP-1 so that GAP_WAIT lasts exactly GAP cycles.
  localparam logic [3:0] GapLoad = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_remaining;
  logic [5:0] r_coinsIssued;
  logic       r_error;
  logic [3:0] r_gapCnt;

  logic [2:0] w_coinCode;
  logic [7:0] w_coinValue;
  logic [7:0] w_remainingAfter;
  logic       w_badAmount;

  // Largest coin that still fits in the remaining amount.
  always_comb begin
    w_coinCode  = 3'd1;
    w_coinValue = 8'd5;
    if (r_remaining >= 8'd25) begin
      w_coinCode  = 3'd4;
      w_coinValue = 8'd25;
    end else if (r_remaining >= 8'd10) begin
      w_coinCode  = 3'd2;
      w_coinValue = 8'd10;
    end
  end

  // Cannot underflow: the chosen coin never exceeds a non-zero multiple of 5.
  assign w_remainingAfter = r_remaining - w_coinValue;
  assign w_badAmount      = (change % 8'd5) != 8'd0;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode. A rejected amount keeps the machine idle. With GAP = 0
  // coins go out back to back, so the machine stays in ISSUE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !w_badAmount) begin
          w_nextState = (change == 8'd0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ack) begin
          if (w_remainingAfter == 8'd0) begin
            w_nextState = S_FINISH;
          end else if (GAP == 0) begin
            w_nextState = S_ISSUE;
          end else begin
            w_nextState = S_GAP_WAIT;
          end
        end
      end
      S_GAP_WAIT: begin
        if (r_gapCnt == 4'd0) begin
          w_nextState = S_ISSUE;
        end
      end
      S_FINISH: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Datapath: this block captures the amount, counts down per coin and times the gap.
  // The error flag changes only when start arrives in IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_remaining   <= 8'd0;
      r_coinsIssued <= 6'd0;
      r_error       <= 1'b0;
      r_gapCnt      <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_badAmount) begin
              r_error <= 1'b1;
            end else begin
              r_error       <= 1'b0;
              r_remaining   <= change;
              r_coinsIssued <= 6'd0;
            end
          end
        end
        S_ISSUE: begin
          if (ack) begin
            r_remaining   <= w_remainingAfter;
            r_coinsIssued <= r_coinsIssued + 6'd1;
            r_gapCnt      <= GapLoad;
          end
        end
        S_GAP_WAIT: begin
          if (r_gapCnt != 4'd0) begin
            r_gapCnt <= r_gapCnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Moore outputs. Because they decode only registers, reset clears them at once.
  assign coin_valid   = (r_state == S_ISSUE);
  assign coin         = coin_valid ? w_coinCode : 3'd0;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_FINISH);
  assign error        = r_error;
  assign remaining    = r_remaining;
  assign coins_issued = r_coinsIssued;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
// Self-checking bench for change_dispenser. Instance dut uses GAP = 2 and
// instance dut0 uses GAP = 0. The expected coin sequences come from a greedy
// split of the amount into quarters, dimes and nickels. Each step is checked
// against the payout rules with per-cycle expectations.
module tb_change_dispenser;

  localparam int GAP_A = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, ack;
  logic [7:0] change;
  logic [2:0] coin;
  logic       coinValid, busy, done, error;
  logic [7:0] remaining;
  logic [5:0] coinsIssued;

  logic       start0, ack0;
  logic [7:0] change0;
  logic [2:0] coin0;
  logic       coinValid0, busy0, done0, error0;
  logic [7:0] remaining0;
  logic [5:0] coinsIssued0;

  int vectors     = 0;
  int miscompares = 0;
  int lastCount   = 0;

  change_dispenser #(.GAP(GAP_A)) dut (
    .clock(clock), .reset(reset), .start(start), .change(change), .ack(ack),
    .coin(coin), .coin_valid(coinValid), .busy(busy), .done(done), .error(error),
    .remaining(remaining), .coins_issued(coinsIssued)
  );

  change_dispenser #(.GAP(0)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .change(change0), .ack(ack0),
    .coin(coin0), .coin_valid(coinValid0), .busy(busy0), .done(done0), .error(error0),
    .remaining(remaining0), .coins_issued(coinsIssued0)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Guard against a stuck simulation.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge, where outputs have settled.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] codeOf(input int value);
    return (value == 25) ? 3'd4 : (value == 10) ? 3'd2 : 3'd1;
  endfunction

  function automatic logic [20:0] pack(input logic cv, input logic [2:0] c, input int rem,
                                       input int cnt, input logic b, input logic d, input logic e);
    return {cv, c, 8'(rem), 6'(cnt), b, d, e};
  endfunction

  function automatic logic [20:0] obs();
    return {coinValid, coin, remaining, coinsIssued, busy, done, error};
  endfunction

  function automatic logic [20:0] obs0();
    return {coinValid0, coin0, remaining0, coinsIssued0, busy0, done0, error0};
  endfunction

  // Greedy split of a multiple of 5 into coin values, largest first.
  function automatic void splitCoins(input int amount, output int vals[$]);
    int rest;
    vals = {};
    rest = amount % 25;
    repeat (amount / 25) vals.push_back(25);
    repeat (rest / 10) vals.push_back(10);
    repeat ((rest % 10) / 5) vals.push_back(5);
  endfunction

  // One payout on dut. Each cycle the ejector accepts with probability ackPct,
  // and it always accepts after 8 waiting cycles. pokeStart holds start high
  // with change = 5 through ISSUE, GAP_WAIT and FINISH, and that must change nothing.
  task automatic payout(input int amount, input int ackPct, input bit pokeStart);
    int vals[$];
    int expRem, expCount, waitCycles;
    bit gotAck;
    logic [20:0] want;
    splitCoins(amount, vals);
    expRem = amount;
    expCount = 0;
    ack = 1'b0;
    start = 1'b1;
    change = 8'(amount);
    tick();
    start = 1'b0;
    foreach (vals[i]) begin
      gotAck = 1'b0;
      waitCycles = 0;
      while (!gotAck) begin
        want = pack(1'b1, codeOf(vals[i]), expRem, expCount, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (obs() !== want) begin
          miscompares++;
          $display("[TB] FAIL issue amt=%0d coin#%0d: got %h want %h", amount, i, obs(), want);
        end
        gotAck = (waitCycles >= 8) || ($urandom_range(0, 99) < ackPct);
        ack = gotAck;
        start = pokeStart;
        change = 8'd5;
        tick();
        waitCycles++;
      end
      ack = 1'b0;
      start = 1'b0;
      expRem -= vals[i];
      expCount++;
      if (expRem != 0) begin
        repeat (GAP_A) begin
          want = pack(1'b0, 3'd0, expRem, expCount, 1'b1, 1'b0, 1'b0);
          vectors++;
          if (obs() !== want) begin
            miscompares++;
            $display("[TB] FAIL gap amt=%0d after coin#%0d: got %h want %h", amount, i, obs(), want);
          end
          ack = 1'($urandom_range(0, 1));
          start = pokeStart;
          tick();
        end
        start = 1'b0;
      end
    end
    ack = 1'b0;
    want = pack(1'b0, 3'd0, 0, expCount, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (obs() !== want) begin
      miscompares++;
      $display("[TB] FAIL finish amt=%0d: got %h want %h", amount, obs(), want);
    end
    start = pokeStart;
    change = 8'd5;
    tick();
    start = 1'b0;
    want = pack(1'b0, 3'd0, 0, expCount, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs() !== want) begin
      miscompares++;
      $display("[TB] FAIL idle after amt=%0d: got %h want %h", amount, obs(), want);
    end
    lastCount = expCount;
  endtask

  // A non-multiple of 5 must only raise error and leave everything else alone.
  task automatic invalidStart(input int amount);
    logic [20:0] want;
    start = 1'b1;
    change = 8'(amount);
    tick();
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      want = pack(1'b0, 3'd0, 0, lastCount, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (obs() !== want) begin
        miscompares++;
        $display("[TB] FAIL invalid amt=%0d cyc%0d: got %h want %h", amount, c, obs(), want);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [20:0] want;
    reset = 1'b0;
    start = 1'b0; ack = 1'b0; change = 8'd0;
    start0 = 1'b0; ack0 = 1'b0; change0 = 8'd0;
    #12;
    want = '0;
    vectors++;
    if (obs() !== want) begin
      miscompares++;
      $display("[TB] FAIL reset dut: got %h want %h", obs(), want);
    end
    vectors++;
    if (obs0() !== want) begin
      miscompares++;
      $display("[TB] FAIL reset dut0: got %h want %h", obs0(), want);
    end
    reset = 1'b1;
    tick();
    lastCount = 0;
  endtask

  task automatic test_basic();
    payout(40, 100, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [20:0] want;
    start = 1'b1;
    change = 8'd25;
    ack = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      want = pack(1'b1, 3'd4, 25, 0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (obs() !== want) begin
        miscompares++;
        $display("[TB] FAIL backpressure hold cyc%0d: got %h want %h", c, obs(), want);
      end
      ack = (c == 5);
      tick();
    end
    ack = 1'b0;
    want = pack(1'b0, 3'd0, 0, 1, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (obs() !== want) begin
      miscompares++;
      $display("[TB] FAIL backpressure done: got %h want %h", obs(), want);
    end
    tick();
    lastCount = 1;
  endtask

  task automatic test_zero_invalid();
    payout(0, 100, 1'b0);
    invalidStart(37);
    payout(10, 100, 1'b0);
  endtask

  // Back-to-back payout on the GAP = 0 instance with ack held high.
  task automatic test_max(input int amount);
    int vals[$];
    int expRem, expCount;
    logic [20:0] want;
    splitCoins(amount, vals);
    expRem = amount;
    expCount = 0;
    ack0 = 1'b1;
    start0 = 1'b1;
    change0 = 8'(amount);
    tick();
    start0 = 1'b0;
    foreach (vals[i]) begin
      want = pack(1'b1, codeOf(vals[i]), expRem, expCount, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (obs0() !== want) begin
        miscompares++;
        $display("[TB] FAIL max amt=%0d coin#%0d: got %h want %h", amount, i, obs0(), want);
      end
      tick();
      expRem -= vals[i];
      expCount++;
    end
    want = pack(1'b0, 3'd0, 0, expCount, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (obs0() !== want) begin
      miscompares++;
      $display("[TB] FAIL max done amt=%0d: got %h want %h", amount, obs0(), want);
    end
    tick();
    ack0 = 1'b0;
  endtask

  task automatic test_start_busy();
    payout(40, 100, 1'b1);
    payout(25, 60, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [20:0] want;
    start = 1'b1;
    change = 8'd45;
    ack = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ack = 1'b0;
    tick();
    tick();
    want = pack(1'b1, 3'd2, 20, 1, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (obs() !== want) begin
      miscompares++;
      $display("[TB] FAIL reset-mid setup: got %h want %h", obs(), want);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (obs() !== 21'd0) begin
      miscompares++;
      $display("[TB] FAIL reset-mid async clear: got %h want %h", obs(), 21'd0);
    end
    ack = 1'b1;
    tick();
    vectors++;
    if (obs() !== 21'd0) begin
      miscompares++;
      $display("[TB] FAIL reset-mid held: got %h want %h", obs(), 21'd0);
    end
    #3;
    reset = 1'b1;
    tick();
    ack = 1'b0;
    vectors++;
    if (obs() !== 21'd0) begin
      miscompares++;
      $display("[TB] FAIL reset-mid released: got %h want %h", obs(), 21'd0);
    end
    lastCount = 0;
    payout(15, 100, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        invalidStart(5 * int'($urandom_range(0, 50)) + int'($urandom_range(1, 4)));
      end else begin
        payout(5 * int'($urandom_range(0, 51)), int'($urandom_range(20, 100)),
               1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_invalid();
    test_max(245);
    test_max(250);
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
